// File: rtl/rx_unit.sv
// rx_unit: oversampling 8N1 UART receiver (LSB first, idle high).
// The serial line is resynchronised, start/stop bits are validated and each
// byte is delivered with a one-cycle valid pulse; a low stop bit gives a
// one-cycle frame_err pulse and the block then waits for the line to go high.
// Optional feature macro: RX_MAJORITY_EN (3-sample majority vote per bit).
module rx_unit #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 is_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TW-1:0] SAMPLE   = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST     = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
`ifdef RX_MAJORITY_EN
    localparam logic [TW-1:0] DECIDE   = TW'(OVERSAMPLE / 2);
`else
    localparam logic [TW-1:0] DECIDE   = TW'(OVERSAMPLE / 2 - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t               state, state_d;
    logic                 sync_meta, rx_s;
    logic [TW-1:0]        tick_cnt, tick_cnt_d;
    logic [BW-1:0]        bit_cnt, bit_cnt_d;
    logic [DATA_BITS-1:0] shift, shift_d;
    logic [DATA_BITS-1:0] data_d;
    logic                 valid_d, ferr_d;
    logic                 bit_val;
    logic                 at_decide, at_wrap;

    // Two-flop synchronizer; both stages rest at the idle-high line level.
    always_ff @(posedge clock) begin
        if (rst) begin
            sync_meta <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            sync_meta <= serial_in;
            rx_s      <= sync_meta;
        end
    end

`ifdef RX_MAJORITY_EN
    logic vote_a, vote_b;

    // Capture the two samples that precede the decision tick for the vote.
    always_ff @(posedge clock) begin
        if (rst) begin
            vote_a <= 1'b1;
            vote_b <= 1'b1;
        end else if (tick) begin
            if (tick_cnt == SAMPLE - TW'(1)) vote_a <= rx_s;
            if (tick_cnt == SAMPLE)          vote_b <= rx_s;
        end
    end

    // The bit value is the majority of the two stored samples and the live one.
    always_comb begin
        bit_val = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);
    end
`else
    // The bit value is the single live sample at the decision tick.
    always_comb begin
        bit_val = rx_s;
    end
`endif

    assign at_decide = tick && (tick_cnt == DECIDE);
    assign at_wrap   = tick && (tick_cnt == LAST);
    assign is_busy   = (state != IDLE);

    // Next-state, counter and output-pulse logic for the frame FSM.
    always_comb begin
        state_d    = state;
        tick_cnt_d = tick_cnt;
        bit_cnt_d  = bit_cnt;
        shift_d    = shift;
        data_d     = data_out;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;

        if (tick && (state == START || state == DATA || state == STOP)) begin
            tick_cnt_d = at_wrap ? '0 : tick_cnt + TW'(1);
        end

        case (state)
            IDLE: begin
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
                if (tick && !rx_s) begin
                    state_d    = START;
                    tick_cnt_d = TW'(1);
                end
            end
            START: begin
                if (at_decide && bit_val) begin
                    state_d    = IDLE;
                    tick_cnt_d = '0;
                end else if (at_wrap) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (at_decide) begin
                    shift_d = {bit_val, shift[DATA_BITS-1:1]};
                end
                if (at_wrap) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (at_decide) begin
                    if (bit_val) begin
                        data_d     = shift;
                        valid_d    = 1'b1;
                        state_d    = IDLE;
                        tick_cnt_d = '0;
                    end else begin
                        ferr_d     = 1'b1;
                        state_d    = BREAK;
                        tick_cnt_d = '0;
                    end
                end
            end
            BREAK: begin
                tick_cnt_d = '0;
                if (tick && rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_d;
            tick_cnt  <= tick_cnt_d;
            bit_cnt   <= bit_cnt_d;
            shift     <= shift_d;
            data_out  <= data_d;
            valid     <= valid_d;
            frame_err <= ferr_d;
        end
    end

endmodule

// File: tb/tb_rx_unit.sv
// tb_rx_unit: self-checking bench for rx_unit (OVERSAMPLE=16, DATA_BITS=8).
// The line is described as one value per tick slot; a slot spans a number of
// clocks ending with a single tick pulse.
module tb_rx_unit;

    logic       clock = 1'b0;
    logic       rst;
    logic       tick;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       is_busy;

    rx_unit #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
        .clock     (clock),
        .rst       (rst),
        .tick      (tick),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .is_busy   (is_busy)
    );

    // Free-running clock.
    always #5 clock = ~clock;

    int   assertions    = 0;
    int   failures      = 0;
    int   valid_cnt     = 0;
    int   ferr_cnt      = 0;
    int   tick_total    = 0;
    int   protocol_errs = 0;
    int   valid_tick[$];
    logic prev_pulse    = 1'b0;
    logic frame_line[160];

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        int         period;
        int         low_hold;
        int         exp_valid;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    // Count ticks as the DUT sees them.
    always @(posedge clock) begin
        if (tick) tick_total++;
    end

    // Observe output pulses away from the active edge.
    always @(negedge clock) begin
        if (valid) begin
            valid_cnt++;
            valid_tick.push_back(tick_total);
        end
        if (frame_err) ferr_cnt++;
        if ((valid && frame_err) || ((valid || frame_err) && prev_pulse)) protocol_errs++;
        prev_pulse = valid || frame_err;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", name, actual, expected);
        end
    endtask

    // One tick slot: line value held for 'p' clocks, tick on the last one.
    task automatic sendSlot(input logic b, input int p);
        for (int i = 0; i < p; i++) begin
            @(negedge clock);
            if (i == 0) serial_in = b;
            tick = (i == p - 1);
        end
    endtask

    task automatic idleSlots(input int n, input logic b, input int p);
        for (int i = 0; i < n; i++) sendSlot(b, p);
    endtask

    // Drive slots [from,to) of the prepared frame; period 0 means jittered.
    task automatic applyStimulus(input int from, input int to, input int period);
        for (int i = from; i < to; i++) begin
            sendSlot(frame_line[i], (period == 0) ? int'($urandom_range(3, 6)) : period);
        end
    endtask

    // Describe a frame slot by slot, with optional glitches in data bits.
    task automatic buildFrame(input logic [7:0] d, input logic stop_ok,
                              input int glitch_slot, input logic rand_glitch);
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < 16; s++) begin
                logic v;
                if (b == 0)      v = 1'b0;
                else if (b == 9) v = stop_ok;
                else             v = d[b-1];
                if (b >= 1 && b <= 8 && s == glitch_slot) v = ~v;
                frame_line[b*16+s] = v;
            end
        end
        if (rand_glitch) begin
            for (int b = 1; b <= 8; b++) begin
                if ($urandom_range(0, 1) == 1) begin
                    int s;
                    s = int'($urandom_range(0, 10));
                    if (s >= 5) s += 5;
                    frame_line[b*16+s] = ~frame_line[b*16+s];
                end
            end
        end
    endtask

    // Reference decision of one bit from the middle of its slot window.
    function automatic logic modelBit(input int b);
`ifdef RX_MAJORITY_EN
        int ones;
        ones = int'(frame_line[b*16+6]) + int'(frame_line[b*16+7]) + int'(frame_line[b*16+8]);
        return (ones >= 2);
`else
        return frame_line[b*16+7];
`endif
    endfunction

    // Reference outcome of the prepared frame.
    task automatic modelFrame(output int ev, output int ef, output logic [7:0] byte_val);
        for (int b = 1; b <= 8; b++) byte_val[b-1] = modelBit(b);
        ev = 0;
        ef = 0;
        if (modelBit(0) == 1'b0) begin
            if (modelBit(9)) ev = 1;
            else             ef = 1;
        end
    endtask

    initial begin
        int         vbase, fbase, qbase;
        int         ev, ef;
        logic [7:0] eb;
        logic [7:0] model_data;

        rst       = 1'b1;
        tick      = 1'b0;
        serial_in = 1'b1;
        repeat (4) @(negedge clock);
        rst = 1'b0;
        @(negedge clock);
        checkOutput("reset data_out", data_out, 0);
        checkOutput("reset valid", valid, 0);
        checkOutput("reset frame_err", frame_err, 0);
        checkOutput("reset is_busy", is_busy, 0);
        idleSlots(4, 1'b1, 4);

        vecs[0] = '{8'hA5, 1'b1, 4, 0,  1, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 4, 20, 0, 1, 8'hA5};
        vecs[2] = '{8'h81, 1'b1, 4, 0,  1, 0, 8'h81};
        vecs[3] = '{8'h00, 1'b1, 1, 0,  1, 0, 8'h00};
        vecs[4] = '{8'h5A, 1'b1, 6, 0,  1, 0, 8'h5A};
        vecs[5] = '{8'hFF, 1'b1, 3, 0,  1, 0, 8'hFF};

        for (int i = 0; i < 6; i++) begin
            vbase = valid_cnt;
            fbase = ferr_cnt;
            buildFrame(vecs[i].data, vecs[i].stop_ok, -1, 1'b0);
            applyStimulus(0, 160, vecs[i].period);
            if (vecs[i].low_hold > 0) idleSlots(vecs[i].low_hold * 16, 1'b0, vecs[i].period);
            idleSlots(20, 1'b1, vecs[i].period);
            checkOutput($sformatf("vec%0d valid count", i), valid_cnt - vbase, vecs[i].exp_valid);
            checkOutput($sformatf("vec%0d frame_err count", i), ferr_cnt - fbase, vecs[i].exp_ferr);
            checkOutput($sformatf("vec%0d data_out", i), data_out, vecs[i].exp_data);
            checkOutput($sformatf("vec%0d is_busy", i), is_busy, 0);
        end

        // Short low glitch: START is entered and then abandoned.
        vbase = valid_cnt;
        fbase = ferr_cnt;
        idleSlots(2, 1'b0, 4);
        checkOutput("glitch is_busy during", is_busy, 1);
        idleSlots(2, 1'b0, 4);
        idleSlots(20, 1'b1, 4);
        checkOutput("glitch valid count", valid_cnt - vbase, 0);
        checkOutput("glitch frame_err count", ferr_cnt - fbase, 0);
        checkOutput("glitch is_busy after", is_busy, 0);

        // Back-to-back frames with a single stop bit.
        qbase = valid_tick.size();
        buildFrame(8'h00, 1'b1, -1, 1'b0);
        applyStimulus(0, 160, 4);
        checkOutput("b2b first data", data_out, 8'h00);
        buildFrame(8'hFF, 1'b1, -1, 1'b0);
        applyStimulus(0, 160, 4);
        idleSlots(8, 1'b1, 4);
        checkOutput("b2b valid count", valid_tick.size() - qbase, 2);
        checkOutput("b2b second data", data_out, 8'hFF);
        if (valid_tick.size() >= qbase + 2) begin
            checkOutput("b2b spacing ticks", valid_tick[qbase+1] - valid_tick[qbase], 160);
        end

        // Reset in the middle of data bit 3 aborts the frame.
        buildFrame(8'h55, 1'b1, -1, 1'b0);
        applyStimulus(0, 72, 4);
        vbase = valid_cnt;
        fbase = ferr_cnt;
        @(negedge clock);
        tick = 1'b0;
        rst  = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        checkOutput("midreset data_out", data_out, 0);
        checkOutput("midreset valid", valid, 0);
        checkOutput("midreset frame_err", frame_err, 0);
        checkOutput("midreset is_busy", is_busy, 0);
        serial_in = 1'b1;
        idleSlots(320, 1'b1, 4);
        checkOutput("midreset no pulses", (valid_cnt - vbase) + (ferr_cnt - fbase), 0);
        applyStimulus(0, 160, 4);
        idleSlots(8, 1'b1, 4);
        checkOutput("after reset valid count", valid_cnt - vbase, 1);
        checkOutput("after reset data", data_out, 8'h55);

        // One-slot inverted glitch at the sample point of every data bit.
        vbase = valid_cnt;
        buildFrame(8'hF0, 1'b1, 7, 1'b0);
        applyStimulus(0, 160, 4);
        idleSlots(8, 1'b1, 4);
        checkOutput("sample glitch valid count", valid_cnt - vbase, 1);
`ifdef RX_MAJORITY_EN
        checkOutput("sample glitch data", data_out, 8'hF0);
`else
        checkOutput("sample glitch data", data_out, 8'h0F);
`endif

        // Randomized frames checked against the slot-level reference model.
        model_data = data_out;
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       ok;
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            buildFrame(d, ok, -1, 1'b1);
            modelFrame(ev, ef, eb);
            if (ev == 1) model_data = eb;
            vbase = valid_cnt;
            fbase = ferr_cnt;
            applyStimulus(0, 160, 0);
            if (!ok) idleSlots(int'($urandom_range(0, 32)), 1'b0, 4);
            idleSlots(int'($urandom_range(2, 10)), 1'b1, 4);
            checkOutput($sformatf("rand%0d valid count", n), valid_cnt - vbase, ev);
            checkOutput($sformatf("rand%0d frame_err count", n), ferr_cnt - fbase, ef);
            checkOutput($sformatf("rand%0d data_out", n), data_out, model_data);
        end

        @(negedge clock);
        tick = 1'b0;
        repeat (4) @(negedge clock);
        checkOutput("pulse exclusivity", protocol_errs, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/rx_unit.md
Name: rx_unit

Overview:
UART receiver that consumes the serial line driven by the team's transmitter (8N1, LSB first, idle high). It oversamples the line using a shared baud-generator pulse, validates start and stop bits, and delivers each byte with a single-cycle valid pulse. It is the downstream peer of the TX stage and uses the same tick source, configured at OVERSAMPLE times the bit rate.

Parameters:
OVERSAMPLE, 16, tick pulses per bit period; even and >= 4
DATA_BITS, 8, data bits per frame; range 5..8

Ports:
clock      input   1          system clock; all logic on posedge
rst        input   1          synchronous active-high reset
tick       input   1          1-cycle enable pulse at OVERSAMPLE x baud
serial_in  input   1          asynchronous RX line, idle high
data_out   output  DATA_BITS  last received byte, LSB = first data bit
valid      output  1          1-cycle pulse, data_out updated this cycle
frame_err  output  1          1-cycle pulse, stop bit sampled low
is_busy    output  1          high from start detection until the frame ends

Behaviour:
- Reset is synchronous and active-high on rst, sampled at the posedge of clock. rst wins over every other input.
- Reset values: data_out=0, valid=0, frame_err=0, is_busy=0, state=IDLE, counters=0, synchronizer flops=1.
- serial_in passes through a 2-flop synchronizer; rx_s is its output. All decisions use rx_s, which adds 2 cycles of latency.
- tick_cnt (0..OVERSAMPLE-1) advances only on tick and wraps to 0. SAMPLE = OVERSAMPLE/2-1 (7 at default).
- DECIDE is SAMPLE (SAMPLE+1 with the optional feature). The bit decision is made on the tick where tick_cnt==DECIDE.
- States:
  - IDLE: on tick with rx_s==0, go to START, tick_cnt=1, is_busy=1. Without tick, no action.
  - START: at DECIDE, if the bit is 1 it is a false start: go to IDLE, is_busy=0. On the tick where tick_cnt==OVERSAMPLE-1, go to DATA with bit_cnt=0.
  - DATA: at DECIDE, shift the bit in at the MSB and shift right, so after DATA_BITS bits the first bit sits at the LSB. At each tick_cnt wrap, bit_cnt++. The wrap after bit DATA_BITS-1 goes to STOP.
  - STOP: at DECIDE:
    - bit=1: data_out<=shift, valid=1 for one cycle, go to IDLE, is_busy=0.
    - bit=0: frame_err=1 for one cycle, data_out unchanged, valid stays 0, go to BREAK.
  - BREAK: on tick with rx_s==1, go to IDLE, is_busy=0. A line held low never generates further frames.
- The block returns to IDLE mid-stop-bit, so back-to-back frames with a 1-bit stop are received without loss.
- valid and frame_err are mutually exclusive and never high for 2 consecutive cycles.
- A tick asserted on consecutive clocks is legal. Each tick advances tick_cnt once.
- Reset mid-frame aborts the frame. No valid or frame_err pulse is produced, and outputs go to reset values in the next cycle.
- Latency: valid rises 1 clock after the stop-bit DECIDE tick, about 9.5 bit periods plus 3 clocks after the start edge on serial_in.

Optional Feature:
RX_MAJORITY_EN
- Defined: each bit equals the majority of rx_s sampled on the ticks at tick_cnt SAMPLE-1, SAMPLE and SAMPLE+1. DECIDE=SAMPLE+1. Start validation uses the same vote.
- Undefined: a single sample at tick_cnt==SAMPLE is used, with DECIDE=SAMPLE. The vote registers are not instantiated.

Test Plan:
1. tick every 4 clocks; send 0xA5 as 8N1, 16 ticks/bit -> exactly one valid pulse with data_out=0xA5, frame_err never set, is_busy low after the pulse.
2. Low glitch of 4 ticks on idle line -> START entered then aborted at DECIDE; no valid, no frame_err, is_busy back to 0.
3. Send 0x3C with stop bit forced 0 and the line kept low 20 bit-times, then high -> one frame_err pulse; data_out keeps its previous value; no further frames until the line is high; the next frame, 0x81, is received correctly.
4. Back-to-back 0x00 then 0xFF with no idle gap -> two valid pulses, data_out=0x00 then 0xFF, spacing 160 ticks.
5. rst asserted for 1 clock at data bit 3 of 0x55 -> no pulse for the aborted frame, all outputs 0; the subsequent 0x55 frame is received correctly.
6. With RX_MAJORITY_EN: 0xF0 with a 1-tick inverted glitch at SAMPLE on each data bit -> data_out=0xF0. Without the macro, the same stimulus -> data_out=0x0F.
